segre_controller: RTL and testbench

- Multicycle sequencing FSM for the Segre core.
- Drives the fsm_state_e bus consumed by the IF, ID, EX, MEM and WB stages, including the IF stage's memory-read and PC-update logic.
- Sequences one instruction at a time through IF→ID→EX→(MEM)→WB, stalling on memory handshakes.
- Also keeps cycle and retired-instruction counters, and flags memory waits that exceed a bound.

---
 rtl/segre_controller.sv | 80 ++++++++
 tb/tb_segre_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/segre_controller.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the Segre core, with cycle/instret
// counters and a sticky flag for memory handshakes that stall too long.
package segre_pkg;
  typedef enum logic [2:0] {
    IF_STATE  = 3'd0,
    ID_STATE  = 3'd1,
    EX_STATE  = 3'd2,
    MEM_STATE = 3'd3,
    WB_STATE  = 3'd4
  } fsm_state_e;
endpackage

module segre_controller
  import segre_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_ready_i,
  input  logic                 mem_op_i,
  output fsm_state_e           fsm_state_o,
  output logic                 state_first_o,
  output logic                 mem_timeout_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_o
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  fsm_state_e        state_next;
  logic              waiting;
  logic              state_change;
  logic [WAIT_W-1:0] wait_cnt;

  always_comb begin
    state_next = IF_STATE;
    case (fsm_state_o)
      IF_STATE:  state_next = mem_ready_i ? ID_STATE : IF_STATE;
      ID_STATE:  state_next = EX_STATE;
      EX_STATE:  state_next = mem_op_i ? MEM_STATE : WB_STATE;
      MEM_STATE: state_next = mem_ready_i ? WB_STATE : MEM_STATE;
      WB_STATE:  state_next = IF_STATE;
      default:   state_next = IF_STATE;
    endcase
  end

  assign state_change = (state_next != fsm_state_o);
  assign waiting = ((fsm_state_o == IF_STATE) || (fsm_state_o == MEM_STATE)) && !mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_state_o   <= IF_STATE;
      state_first_o <= 1'b1;
      mem_timeout_o <= 1'b0;
      cycle_cnt_o   <= '0;
      instret_o     <= '0;
      wait_cnt      <= '0;
    end else begin
      fsm_state_o   <= state_next;
      state_first_o <= state_change;
      cycle_cnt_o   <= cycle_cnt_o + CNT_WIDTH'(1);

      if (fsm_state_o == WB_STATE)
        instret_o <= instret_o + CNT_WIDTH'(1);

      if (state_change)
        wait_cnt <= '0;
      else if (waiting && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + WAIT_W'(1);

      // A limit-reached count still flags even if ready arrives in that same cycle.
      if (wait_cnt == WAIT_MAX)
        mem_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_segre_controller.sv
// Bench for segre_controller: a small-parameter and a default-parameter instance
// driven together and checked each cycle against a cycle-level behavioural model.
module tb_segre_controller;
  import segre_pkg::*;

  localparam int T_SMALL = 4;
  localparam int T_BIG   = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ready = 1'b0;
  logic op = 1'b0;

  fsm_state_e  s_state, b_state;
  logic        s_first, b_first, s_to, b_to;
  logic [3:0]  s_cyc, s_ret;
  logic [63:0] b_cyc, b_ret;

  int errors = 0;
  int checks = 0;

  segre_controller #(.TIMEOUT_CYCLES(T_SMALL), .CNT_WIDTH(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .mem_ready_i(ready), .mem_op_i(op),
    .fsm_state_o(s_state), .state_first_o(s_first), .mem_timeout_o(s_to),
    .cycle_cnt_o(s_cyc), .instret_o(s_ret)
  );

  segre_controller dut_b (
    .clk_i(clk), .rst_i(rst), .mem_ready_i(ready), .mem_op_i(op),
    .fsm_state_o(b_state), .state_first_o(b_first), .mem_timeout_o(b_to),
    .cycle_cnt_o(b_cyc), .instret_o(b_ret)
  );

  always #5 clk = ~clk;

  // Behavioural model: stall counts the not-ready cycles of the current visit
  // (unbounded), so the flag is simply "a visit has already stalled T times".
  fsm_state_e m_state;
  bit         m_first, m_to_s, m_to_b, valid = 0;
  longint     m_cyc, m_ret;
  int         stall;

  always @(posedge clk) begin
    fsm_state_e nxt;
    if (rst) begin
      m_state = IF_STATE; m_first = 1; m_to_s = 0; m_to_b = 0;
      m_cyc = 0; m_ret = 0; stall = 0; valid = 1;
    end else if (valid) begin
      m_cyc++;
      if (stall >= T_SMALL) m_to_s = 1;
      if (stall >= T_BIG) m_to_b = 1;
      nxt = m_state;
      if (m_state == IF_STATE && ready) nxt = ID_STATE;
      else if (m_state == ID_STATE) nxt = EX_STATE;
      else if (m_state == EX_STATE) nxt = op ? MEM_STATE : WB_STATE;
      else if (m_state == MEM_STATE && ready) nxt = WB_STATE;
      else if (m_state == WB_STATE) begin nxt = IF_STATE; m_ret++; end
      if (nxt != m_state) stall = 0;
      else stall++;
      m_first = (nxt != m_state);
      m_state = nxt;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      check("s_state", 64'(s_state), 64'(m_state));
      check("s_first", 64'(s_first), 64'(m_first));
      check("s_timeout", 64'(s_to), 64'(m_to_s));
      check("s_cycle", 64'(s_cyc), 64'(m_cyc & 15));
      check("s_instret", 64'(s_ret), 64'(m_ret & 15));
      check("b_state", 64'(b_state), 64'(m_state));
      check("b_first", 64'(b_first), 64'(m_first));
      check("b_timeout", 64'(b_to), 64'(m_to_b));
      check("b_cycle", b_cyc, 64'(m_cyc));
      check("b_instret", b_ret, 64'(m_ret));
    end
  end

  task automatic drive(input logic r, input logic rd, input logic o);
    rst = r; ready = rd; op = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Zero-wait non-memory instruction
    drive(1, 1, 0);
    check("rst_state", 64'(s_state), 64'(IF_STATE));
    check("rst_first", 64'(s_first), 64'd1);
    check("rst_cycle", 64'(b_cyc), 64'd0);
    drive(0, 1, 0); check("seq_id", 64'(s_state), 64'(ID_STATE)); check("seq_first1", 64'(s_first), 64'd1);
    drive(0, 1, 0); check("seq_ex", 64'(s_state), 64'(EX_STATE)); check("seq_first2", 64'(s_first), 64'd1);
    drive(0, 1, 0); check("seq_wb", 64'(s_state), 64'(WB_STATE)); check("seq_first3", 64'(s_first), 64'd1);
    drive(0, 1, 0); check("seq_if", 64'(s_state), 64'(IF_STATE));
    check("seq_instret", b_ret, 64'd1);
    check("seq_cycle", b_cyc, 64'd4);

    // Load/store with 3 stalled MEM cycles
    drive(0, 1, 1); check("mem_id", 64'(s_state), 64'(ID_STATE));
    drive(0, 0, 1); check("mem_ex", 64'(s_state), 64'(EX_STATE));
    drive(0, 0, 1); check("mem_enter", 64'(s_state), 64'(MEM_STATE)); check("mem_first", 64'(s_first), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      check("mem_hold", 64'(s_state), 64'(MEM_STATE));
      check("mem_first_low", 64'(s_first), 64'd0);
    end
    drive(0, 1, 0); check("mem_wb", 64'(s_state), 64'(WB_STATE));
    drive(0, 0, 0); check("mem_retire", b_ret, 64'd2);

    // Timeout in IF with limit 4
    drive(1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0);
    check("to_stall_state", 64'(s_state), 64'(IF_STATE));
    check("to_not_yet", 64'(s_to), 64'd0);
    drive(0, 1, 0);
    check("to_advance", 64'(s_state), 64'(ID_STATE));
    check("to_set", 64'(s_to), 64'd1);
    for (int i = 0; i < 8; i++) drive(0, 1, 0);
    check("to_sticky", 64'(s_to), 64'd1);

    // Reset while in MEM
    drive(0, 0, 1); drive(0, 0, 1);
    check("rmem_in_mem", 64'(s_state), 64'(MEM_STATE));
    drive(1, 0, 0);
    check("rmem_state", 64'(s_state), 64'(IF_STATE));
    check("rmem_instret", 64'(s_ret), 64'd0);
    check("rmem_cycle", 64'(s_cyc), 64'd0);
    check("rmem_timeout", 64'(s_to), 64'd0);

    // 16 zero-wait instructions wrap the 4-bit counters
    drive(1, 1, 0);
    for (int i = 0; i < 63; i++) drive(0, 1, 0);
    check("wrap_cycle15", 64'(s_cyc), 64'd15);
    check("wrap_ret15", 64'(s_ret), 64'd15);
    drive(0, 1, 0);
    check("wrap_cycle0", 64'(s_cyc), 64'd0);
    check("wrap_ret0", 64'(s_ret), 64'd0);
    check("wrap_big_ret", b_ret, 64'd16);

    // Long IF stall trips the default-limit instance
    drive(1, 0, 0);
    for (int i = 0; i < 257; i++) drive(0, 0, $urandom_range(0, 1));
    check("big_to", 64'(b_to), 64'd1);
    drive(0, 1, 0);

    // Random traffic, including toggling inputs in ID/EX/WB and rare resets
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        int n = $urandom_range(3, 9);
        for (int k = 0; k < n; k++) drive(0, 0, $urandom_range(0, 1));
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
